// File: rtl/codec74_pkg.sv
// Shared constants and helpers for the cyclic (7,4) Hamming codec, g(x) = x^3 + x + 1.
// The encoder-side checker uses the same syndrome-to-position map.
package codec74_pkg;

    localparam int N = 7;
    localparam int K = 4;
    localparam logic [2:0] G_POLY = 3'b011;

    typedef enum logic {
        ST_IDLE,
        ST_RECV
    } rx_state_e;

    // One division step: the bit enters at x^0 and the x^3 overflow folds back through g.
    function automatic logic [2:0] lfsr_step(input logic [2:0] s, input logic d);
        return {s[1], s[0], d} ^ ({3{s[2]}} & G_POLY);
    endfunction

    // Syndrome equals x^i mod g(x) for a single error at c_i.
    function automatic logic [2:0] syn2pos(input logic [2:0] s);
        logic [2:0] pos;
        case (s)
            3'b001:  pos = 3'd0;
            3'b010:  pos = 3'd1;
            3'b100:  pos = 3'd2;
            3'b011:  pos = 3'd3;
            3'b110:  pos = 3'd4;
            3'b111:  pos = 3'd5;
            3'b101:  pos = 3'd6;
            default: pos = 3'd0;
        endcase
        return pos;
    endfunction

endpackage

// File: rtl/syndrome_lfsr.sv
// Syndrome register: divides the received polynomial by g(x), one bit per shift.
// clr with shift starts a fresh frame from this bit; clr alone empties the register.
module syndrome_lfsr
    import codec74_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       shift,
    input  logic       din,
    output logic [2:0] syn
);

    logic [2:0] syn_q;
    logic [2:0] syn_d;

    always_comb begin
        syn_d = syn_q;
        if (clr && shift) begin
            syn_d = lfsr_step(3'b000, din);
        end else if (clr) begin
            syn_d = 3'b000;
        end else if (shift) begin
            syn_d = lfsr_step(syn_q, din);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syn_q <= 3'b000;
        end else begin
            syn_q <= syn_d;
        end
    end

    assign syn = syn_q;

endmodule

// File: rtl/cyclic74_decoder.sv
// Serial decoder for the systematic cyclic (7,4) Hamming code.
// Collects 7 bits MSB-first, corrects a single error and emits the message in parallel and serially.
module cyclic74_decoder
    import codec74_pkg::*;
#(
    parameter bit CORRECT_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         din,
    input  logic         din_valid,
    input  logic         frame_start,
    output logic [K-1:0] word_out,
    output logic         word_valid,
    output logic         err,
    output logic [2:0]   err_pos,
    output logic         dout,
    output logic         dout_valid
);

    rx_state_e    state_q;
    logic [2:0]   bit_cnt_q;
    logic [N-1:0] buf_q;
    logic [2:0]   syn;

    logic         restart;
    logic         last;
    logic         lfsr_clr;
    logic         lfsr_shift;
    logic [N-1:0] frame_full;
    logic [2:0]   syn_full;
    logic [2:0]   pos_full;
    logic         err_full;
    logic [N-1:0] flip_mask;
    logic [N-1:0] corrected;

    logic [K-1:0] word_q;
    logic         word_valid_q;
    logic         err_q;
    logic [2:0]   err_pos_q;
    logic         dout_q;
    logic         dout_valid_q;
    logic [K-2:0] sh_q;
    logic [1:0]   emit_cnt_q;

    // A frame_start always wins, even on what would have been the 7th bit.
    assign restart    = din_valid && frame_start;
    assign last       = din_valid && !frame_start && (state_q == ST_RECV) && (bit_cnt_q == 3'd6);
    assign lfsr_clr   = restart || last;
    assign lfsr_shift = din_valid && ((state_q == ST_RECV) || frame_start) && !last;

    syndrome_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (lfsr_clr),
        .shift (lfsr_shift),
        .din   (din),
        .syn   (syn)
    );

    // Final syndrome includes c0, which is still on din at the closing clock.
    assign frame_full = {buf_q[N-2:0], din};
    assign syn_full   = lfsr_step(syn, din);
    assign err_full   = |syn_full;
    assign pos_full   = syn2pos(syn_full);
    assign flip_mask  = (CORRECT_EN && err_full) ? ({{(N-1){1'b0}}, 1'b1} << pos_full) : '0;
    assign corrected  = frame_full ^ flip_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            buf_q     <= '0;
        end else if (restart) begin
            state_q   <= ST_RECV;
            bit_cnt_q <= 3'd1;
            buf_q     <= frame_full;
        end else if (state_q == ST_RECV) begin
            if (din_valid) begin
                buf_q     <= frame_full;
                bit_cnt_q <= last ? 3'd0 : bit_cnt_q + 3'd1;
            end else if (bit_cnt_q == 3'd0) begin
                state_q <= ST_IDLE;
            end
        end
    end

    // Output stage: emission runs on clock alone, four cycles per word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q       <= '0;
            word_valid_q <= 1'b0;
            err_q        <= 1'b0;
            err_pos_q    <= 3'd0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            sh_q         <= '0;
            emit_cnt_q   <= 2'd0;
        end else begin
            word_valid_q <= 1'b0;
            if (last) begin
                word_q       <= corrected[N-1 -: K];
                word_valid_q <= 1'b1;
                err_q        <= err_full;
                err_pos_q    <= pos_full;
                dout_q       <= corrected[N-1];
                dout_valid_q <= 1'b1;
                sh_q         <= corrected[N-2 -: K-1];
                emit_cnt_q   <= 2'd3;
            end else if (emit_cnt_q != 2'd0) begin
                dout_q       <= sh_q[K-2];
                dout_valid_q <= 1'b1;
                sh_q         <= {sh_q[K-3:0], 1'b0};
                emit_cnt_q   <= emit_cnt_q - 2'd1;
            end else begin
                dout_q       <= 1'b0;
                dout_valid_q <= 1'b0;
            end
        end
    end

    assign word_out   = word_q;
    assign word_valid = word_valid_q;
    assign err        = err_q;
    assign err_pos    = err_pos_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_cyclic74_decoder.sv
// Directed bench for cyclic74_decoder: hand-computed codewords, a word scoreboard and a serial-output monitor.
// A second instance with correction disabled shares the same stimulus.
module tb_cyclic74_decoder;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic din = 1'b0;
    logic din_valid = 1'b0;
    logic frame_start = 1'b0;

    logic [3:0] wo0, wo1;
    logic       wv0, wv1, er0, er1, do0, do1, dv0, dv1;
    logic [2:0] ep0, ep1;

    cyclic74_decoder #(.CORRECT_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .frame_start(frame_start),
        .word_out(wo0), .word_valid(wv0), .err(er0), .err_pos(ep0), .dout(do0), .dout_valid(dv0)
    );

    cyclic74_decoder #(.CORRECT_EN(1'b0)) u_det (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .frame_start(frame_start),
        .word_out(wo1), .word_valid(wv1), .err(er1), .err_pos(ep1), .dout(do1), .dout_valid(dv1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    typedef struct {
        logic [3:0] w;
        logic       e;
        logic [2:0] p;
        int         c;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e_cur;
    int         pend = 0;
    logic [3:0] emit_w = 4'd0;
    bit         mon_en = 1'b0;

    // Scoreboard: every word_valid must match the oldest expected frame, then 3 more serial bits follow.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_n) begin
                pend = 0;
            end else if (wv0) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_word_valid", 1, 0);
                end else begin
                    e_cur = exp_q.pop_front();
                    check_eq("word_out", wo0, e_cur.w);
                    check_eq("err", er0, e_cur.e);
                    check_eq("err_pos", ep0, e_cur.p);
                    check_eq("word_valid_cycle", cyc, e_cur.c);
                    check_eq("dout_m3", {dv0, do0}, {1'b1, e_cur.w[3]});
                    emit_w = e_cur.w;
                    pend = 3;
                end
            end else if (pend > 0) begin
                check_eq("dout_bit", {dv0, do0}, {1'b1, emit_w[pend-1]});
                pend--;
            end else begin
                check_eq("dout_valid_idle", dv0, 0);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            din = 1'b0; din_valid = 1'b0; frame_start = 1'b0;
        end
    endtask

    task automatic send_bit(input logic b, input logic fs, input int gap);
        idle(gap);
        @(negedge clk);
        din = b; din_valid = 1'b1; frame_start = fs;
    endtask

    task automatic send_frame(input logic [6:0] cw, input logic [3:0] w, input logic e,
                              input logic [2:0] p, input int maxgap);
        for (int i = 6; i >= 0; i--) begin
            send_bit(cw[i], (i == 6), (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
            if (i == 0) exp_q.push_back('{w, e, p, cyc + 1});
        end
    endtask

    logic [6:0] b2b_cw [4] = '{7'b1011000, 7'b1111011, 7'b0001010, 7'b0000000};
    logic [3:0] b2b_w  [4] = '{4'b1011, 4'b1111, 4'b0001, 4'b0000};
    logic       b2b_e  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0] b2b_p  [4] = '{3'd0, 3'd2, 3'd0, 3'd0};

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_word_valid", wv0, 0);
        check_eq("rst_word_out", wo0, 0);
        check_eq("rst_err", er0, 0);
        check_eq("rst_err_pos", ep0, 0);
        check_eq("rst_dout", do0, 0);
        check_eq("rst_dout_valid", dv0, 0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        idle(2);

        // Clean codeword, then the same word with c6 flipped.
        send_frame(7'b1011000, 4'b1011, 1'b0, 3'd0, 0);
        idle(6);
        send_frame(7'b0011000, 4'b1011, 1'b1, 3'd6, 0);
        idle(6);

        // Every single-bit error position on codeword 0001011.
        send_frame(7'b0001011, 4'b0001, 1'b0, 3'd0, 0);
        idle(3);
        for (int i = 0; i < 7; i++) begin
            logic [6:0] cw;
            cw = 7'b0001011 ^ (7'd1 << i);
            send_frame(cw, 4'b0001, 1'b1, 3'(i), 0);
            idle(2);
        end
        idle(4);

        // Back-to-back frames, then the same frames with random valid gaps.
        for (int k = 0; k < 4; k++) send_frame(b2b_cw[k], b2b_w[k], b2b_e[k], b2b_p[k], 0);
        idle(6);
        for (int k = 0; k < 4; k++) send_frame(b2b_cw[k], b2b_w[k], b2b_e[k], b2b_p[k], 3);
        idle(6);

        // Restart on the 4th bit: the first three bits are discarded.
        send_bit(1'b1, 1'b1, 0);
        send_bit(1'b0, 1'b0, 0);
        send_bit(1'b1, 1'b0, 0);
        send_frame(7'b0101100, 4'b0101, 1'b0, 3'd0, 0);
        idle(6);

        // Reset in the middle of serial emission.
        send_frame(7'b1011000, 4'b1011, 1'b0, 3'd0, 0);
        idle(2);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_dout_valid", dv0, 0);
        check_eq("async_rst_dout", do0, 0);
        check_eq("async_rst_word_out", wo0, 0);
        check_eq("async_rst_err", er0, 0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        send_frame(7'b0001011, 4'b0001, 1'b0, 3'd0, 0);
        idle(6);

        // Detect-only instance passes the raw message but still flags the error.
        send_frame(7'b0011000, 4'b1011, 1'b1, 3'd6, 0);
        @(negedge clk);
        din = 1'b0; din_valid = 1'b0; frame_start = 1'b0;
        check_eq("det_word_valid", wv1, 1);
        check_eq("det_word_out", wo1, 4'b0011);
        check_eq("det_err", er1, 1);
        check_eq("det_err_pos", ep1, 6);
        idle(8);

        check_eq("all_words_seen", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
